// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with sequential fetch, redirect flush and a small FWFT queue
//
// Ports:
//   i_clock        clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   o_imem_req     fetch request, held until i_imem_ack
//   o_imem_addr    word-aligned fetch address, stable while o_imem_req is high
//   i_imem_ack     memory returns i_imem_rdata this cycle (ignored while o_imem_req is low)
//   i_imem_rdata   fetched instruction word
//   i_redirect     one-cycle pulse: flush the queue and restart fetch at i_redirect_pc
//   i_redirect_pc  new fetch address (low two bits ignored)
//   o_instr_valid  head entry valid
//   o_instr        head instruction word
//   o_instr_pc     PC of the head instruction
//   i_instr_ready  core consumes the head when valid and ready
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    input  logic        i_instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_addr;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [31:0]   r_ins [DEPTH];
    logic [31:0]   r_pcs [DEPTH];

    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_count;
    logic [31:0] w_next_pc;
    logic [31:0] w_redir_pc;

    // An ack only means something while a request is on the bus.
    assign w_ack      = i_imem_ack && (r_state != IDLE);
    assign w_push     = (r_state == REQ) && w_ack;
    assign w_pop      = o_instr_valid && i_instr_ready;
    assign w_count    = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_next_pc  = r_req_addr + 32'd4;
    assign w_redir_pc = {i_redirect_pc[31:2], 2'b00};

    assign o_imem_req    = (r_state != IDLE);
    assign o_imem_addr   = r_req_addr;
    assign o_instr_valid = (r_count != '0);
    assign o_instr       = r_ins[r_rd];
    assign o_instr_pc    = r_pcs[r_rd];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ins[i] <= '0;
                r_pcs[i] <= '0;
            end
        end else if (i_redirect) begin
            // Flush wins over any push/pop this cycle; the returning word (if any) is dropped.
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            r_fetch_pc <= w_redir_pc;
            if (r_state == IDLE || w_ack) begin
                r_state    <= REQ;
                r_req_addr <= w_redir_pc;
            end else begin
                // A request is still pending at the old address: wait it out.
                r_state <= DROP;
            end
        end else begin
            if (w_push) begin
                r_ins[r_wr] <= i_imem_rdata;
                r_pcs[r_wr] <= r_req_addr;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= w_count;
            if (r_state == IDLE && r_count < FULL) begin
                r_state    <= REQ;
                r_req_addr <= r_fetch_pc;
            end else if (r_state == REQ && w_ack) begin
                r_fetch_pc <= w_next_pc;
                if (w_count < FULL)
                    r_req_addr <= w_next_pc;
                else
                    r_state <= IDLE;
            end else if (r_state == DROP && w_ack) begin
                r_state    <= REQ;
                r_req_addr <= r_fetch_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scoreboard bench for fetch_queue with a variable-latency memory model
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int lat = 1;
    int wcnt = 0;
    logic mem_en = 1'b0;
    logic stray = 1'b0;
    logic m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
        .i_instr_ready(i_instr_ready)
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    assign i_imem_ack   = m_ack | stray;
    assign i_imem_rdata = stray ? 32'hDEAD_BEEF : m_rdata;

    // Memory: acks on the lat-th cycle a request has been held; a new request starts after each ack.
    always @(negedge clk) begin
        if (!mem_en || !o_imem_req) begin
            m_ack = 1'b0;
            wcnt  = 0;
        end else begin
            if (m_ack) wcnt = 0;
            wcnt++;
            m_ack   = (wcnt >= lat);
            m_rdata = img(o_imem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) sb.push_back({base + 32'(4*k), img(base + 32'(4*k))});
    endtask

    // One clock: a consumption at the coming edge is scored first, then inputs may change at edge+1.
    task automatic cyc();
        logic [63:0] e;
        if (o_instr_valid && i_instr_ready && !i_redirect && !i_reset) begin
            pops++;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_extra_pop observed_pc=%h expected=none", o_instr_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("head_pc", o_instr_pc, e[63:32]);
                chk("head_instr", o_instr, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input int l);
        i_reset = 1'b1;
        mem_en = 1'b0;
        i_instr_ready = 1'b0;
        repeat (n) cyc();
        i_reset = 1'b0;
        mem_en = 1'b1;
        lat = l;
        sb.delete();
        pops = 0;
    endtask

    initial begin
        // Reset values, then single-cycle memory with ready high
        i_reset = 1'b1;
        repeat (2) cyc();
        chk("rst_req", 32'(o_imem_req), 32'd0);
        chk("rst_addr", o_imem_addr, 32'd0);
        chk("rst_valid", 32'(o_instr_valid), 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_pc", o_instr_pc, 32'd0);
        do_reset(1, 1);
        push_seq(32'h0, 16);
        i_instr_ready = 1'b1;
        cyc();
        chk("p1_req", 32'(o_imem_req), 32'd1);
        chk("p1_addr", o_imem_addr, 32'd0);
        chk("p1_valid0", 32'(o_instr_valid), 32'd0);
        cyc();
        chk("p1_first_valid", 32'(o_instr_valid), 32'd1);
        chk("p1_first_pc", o_instr_pc, 32'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("p1_stream_valid", 32'(o_instr_valid), 32'd1);
        end
        chk("p1_pops", 32'(pops), 32'd6);

        // Back-pressure: exactly DEPTH requests, then one pop frees one more request
        do_reset(2, 1);
        push_seq(32'h0, 5);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("p2_req", 32'(o_imem_req), 32'd1);
            chk("p2_addr", o_imem_addr, 32'(4*k));
        end
        cyc();
        chk("p2_full_req", 32'(o_imem_req), 32'd0);
        chk("p2_full_pc", o_instr_pc, 32'd0);
        cyc();
        chk("p2_idle_req", 32'(o_imem_req), 32'd0);
        i_instr_ready = 1'b1;
        cyc();
        i_instr_ready = 1'b0;
        chk("p2_after_pop_req", 32'(o_imem_req), 32'd0);
        cyc();
        chk("p2_new_req", 32'(o_imem_req), 32'd1);
        chk("p2_new_addr", o_imem_addr, 32'h10);
        cyc();
        chk("p2_refull_req", 32'(o_imem_req), 32'd0);
        chk("p2_head_pc", o_instr_pc, 32'h4);
        cyc();
        chk("p2_one_req_only", 32'(o_imem_req), 32'd0);
        chk("p2_pops", 32'(pops), 32'd1);

        // Three-cycle memory: address held, one entry per three cycles
        do_reset(2, 3);
        for (int k = 0; k < 7; k++) begin
            cyc();
            chk("p3_req", 32'(o_imem_req), 32'd1);
            chk("p3_addr", o_imem_addr, 32'((k / 3) * 4));
            chk("p3_valid", 32'(o_instr_valid), 32'(k >= 3));
        end

        // Redirect while the 0x8 fetch is outstanding
        i_redirect = 1'b1;
        i_redirect_pc = 32'h103;
        sb.delete();
        push_seq(32'h100, 8);
        pops = 0;
        cyc();
        i_redirect = 1'b0;
        chk("p4_flush_valid", 32'(o_instr_valid), 32'd0);
        chk("p4_drop_req", 32'(o_imem_req), 32'd1);
        chk("p4_drop_addr", o_imem_addr, 32'h8);
        i_instr_ready = 1'b1;
        cyc();
        chk("p4_drop_hold", o_imem_addr, 32'h8);
        cyc();
        chk("p4_new_req", 32'(o_imem_req), 32'd1);
        chk("p4_new_addr", o_imem_addr, 32'h100);
        chk("p4_still_empty", 32'(o_instr_valid), 32'd0);
        for (int k = 0; k < 30 && pops < 2; k++) cyc();
        chk("p4_pops", 32'(pops >= 2), 32'd1);

        // Redirect on the same edge as an ack and a pop
        do_reset(2, 1);
        repeat (4) cyc();
        chk("p5_pre_addr", o_imem_addr, 32'hC);
        chk("p5_pre_pc", o_instr_pc, 32'h0);
        i_redirect = 1'b1;
        i_redirect_pc = 32'h200;
        i_instr_ready = 1'b1;
        sb.delete();
        cyc();
        i_redirect = 1'b0;
        push_seq(32'h200, 8);
        chk("p5_flush_valid", 32'(o_instr_valid), 32'd0);
        chk("p5_req", 32'(o_imem_req), 32'd1);
        chk("p5_addr", o_imem_addr, 32'h200);
        for (int k = 0; k < 30 && pops < 3; k++) cyc();
        chk("p5_pops", 32'(pops >= 3), 32'd1);

        // Reset mid-transaction with a stray ack
        do_reset(2, 1);
        repeat (4) cyc();
        chk("p6_pre_valid", 32'(o_instr_valid), 32'd1);
        chk("p6_pre_req", 32'(o_imem_req), 32'd1);
        i_reset = 1'b1;
        mem_en = 1'b0;
        stray = 1'b1;
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("p6_rst_req", 32'(o_imem_req), 32'd0);
            chk("p6_rst_valid", 32'(o_instr_valid), 32'd0);
            chk("p6_rst_addr", o_imem_addr, 32'd0);
        end
        i_reset = 1'b0;
        cyc();
        chk("p6_rel_req", 32'(o_imem_req), 32'd1);
        chk("p6_rel_addr", o_imem_addr, 32'd0);
        chk("p6_rel_valid", 32'(o_instr_valid), 32'd0);
        stray = 1'b0;
        mem_en = 1'b1;
        i_instr_ready = 1'b1;
        pops = 0;
        push_seq(32'h0, 8);
        for (int k = 0; k < 30 && pops < 2; k++) cyc();
        chk("p6_pops", 32'(pops >= 2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
